snake_body: RTL and testbench

- Movement engine for the snake; the responder side of the game-state interface.
- Consumes `init_snake`, `screen_pause` and `key_code` from the game-state FSM and produces the `died` event that FSM waits on.
- Holds head/body segment coordinates, steps the snake on a divided tick, and detects wall and self collisions.
- Also answers per-pixel-cell "is snake" queries for the display path.

---
 rtl/snake_pkg.sv | 47 ++++
 rtl/snake_tick_div.sv | 32 +++
 rtl/snake_body.sv | 206 ++++++++++++++++++++
 tb/tb_snake_body.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/snake_pkg.sv
// Shared types and constants for the snake movement engine: directions, FSM states,
// PS/2 set-2 key codes and the grid coordinate struct.
package snake_pkg;

  localparam int COORD_W = 8;

  typedef enum logic [1:0] {UP, DOWN, LEFT, RIGHT} dir_t;

  typedef enum logic {ALIVE, DEAD} state_t;

  localparam logic [7:0] KEY_UP    = 8'h1D;
  localparam logic [7:0] KEY_DOWN  = 8'h1B;
  localparam logic [7:0] KEY_LEFT  = 8'h1C;
  localparam logic [7:0] KEY_RIGHT = 8'h23;

  typedef struct packed {
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
  } coord_t;

  function automatic logic keyValid(input logic [7:0] key);
    return (key == KEY_UP) || (key == KEY_DOWN) || (key == KEY_LEFT) || (key == KEY_RIGHT);
  endfunction

  function automatic dir_t keyDir(input logic [7:0] key);
    dir_t d;
    case (key)
      KEY_UP:   d = UP;
      KEY_DOWN: d = DOWN;
      KEY_LEFT: d = LEFT;
      default:  d = RIGHT;
    endcase
    return d;
  endfunction

  function automatic dir_t reverseOf(input dir_t d);
    dir_t r;
    case (d)
      UP:      r = DOWN;
      DOWN:    r = UP;
      LEFT:    r = RIGHT;
      default: r = LEFT;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/snake_tick_div.sv
// Movement tick divider: counts enabled cycles and emits a one-cycle step strobe
// on the cycle the count wraps from DIV-1 back to 0.
module snake_tick_div #(
  parameter int DIV = 5000000
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clear,
  input  logic i_en,
  output logic o_step
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] r_cnt;
  logic          w_wrap;

  assign w_wrap = (r_cnt == LAST);

  always_ff @(posedge clk) begin
    if (rst || i_clear) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= w_wrap ? '0 : r_cnt + CW'(1);
    end
  end

  // The strobe is masked by reset/clear so a reset landing on a wrap cycle never steps.
  assign o_step = i_en && w_wrap && !rst && !i_clear;

endmodule

// File: rtl/snake_body.sv
// Snake movement engine: segment storage, stepping, wall/self collision and cell query.
// Optional macro SNAKE_WRAP_EN makes wall exits wrap to the opposite edge instead of killing.
module snake_body
  import snake_pkg::*;
#(
  parameter int GRID_W   = 32,
  parameter int GRID_H   = 24,
  parameter int MAX_LEN  = 16,
  parameter int INIT_LEN = 4,
  parameter int TICK_DIV = 5000000
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         init_snake,
  input  logic                         screen_pause,
  input  logic [7:0]                   key_code,
  input  logic                         grow,
  output logic                         died,
  output logic [$clog2(GRID_W)-1:0]    head_x,
  output logic [$clog2(GRID_H)-1:0]    head_y,
  output logic [$clog2(MAX_LEN+1)-1:0] length,
  input  logic [$clog2(GRID_W)-1:0]    q_x,
  input  logic [$clog2(GRID_H)-1:0]    q_y,
  output logic                         q_hit
);

  localparam int XW = $clog2(GRID_W);
  localparam int YW = $clog2(GRID_H);
  localparam int LW = $clog2(MAX_LEN + 1);

  localparam logic [COORD_W-1:0] X_MAX = COORD_W'(GRID_W - 1);
  localparam logic [COORD_W-1:0] Y_MAX = COORD_W'(GRID_H - 1);

  state_t r_state;
  state_t w_stateNext;
  dir_t   r_dir;
  dir_t   r_dirPend;
  dir_t   w_dirReq;

  coord_t          r_seg [MAX_LEN];
  logic [LW-1:0]   r_len;
  logic            r_growPend;
  logic            r_died;
  logic            r_qHit;

  logic   w_hold;
  logic   w_live;
  logic   w_step;
  logic   w_keyOk;
  logic   w_growing;
  coord_t w_next;
  coord_t w_query;
  logic   w_wall;
  logic   w_wallKill;
  logic   w_selfHit;
  logic   w_collide;
  logic   w_qHit;

  assign w_hold = rst || init_snake;
  assign w_live = (r_state == ALIVE) && !screen_pause;

  snake_tick_div #(
    .DIV (TICK_DIV)
  ) u_tick (
    .clk     (clk),
    .rst     (rst),
    .i_clear (init_snake),
    .i_en    (w_live),
    .o_step  (w_step)
  );

  // Reverse requests are judged against the committed direction, not the pending one.
  assign w_keyOk   = w_live && keyValid(key_code) && (keyDir(key_code) != reverseOf(r_dir));
  assign w_dirReq  = w_keyOk ? keyDir(key_code) : r_dirPend;
  assign w_growing = (r_growPend || grow) && (r_len < LW'(MAX_LEN));

  always_comb begin
    w_next = r_seg[0];
    w_wall = 1'b0;
    case (w_dirReq)
      UP: begin
        if (r_seg[0].y == '0) begin
          w_wall   = 1'b1;
          w_next.y = Y_MAX;
        end else begin
          w_next.y = r_seg[0].y - COORD_W'(1);
        end
      end
      DOWN: begin
        if (r_seg[0].y == Y_MAX) begin
          w_wall   = 1'b1;
          w_next.y = '0;
        end else begin
          w_next.y = r_seg[0].y + COORD_W'(1);
        end
      end
      LEFT: begin
        if (r_seg[0].x == '0) begin
          w_wall   = 1'b1;
          w_next.x = X_MAX;
        end else begin
          w_next.x = r_seg[0].x - COORD_W'(1);
        end
      end
      default: begin
        if (r_seg[0].x == X_MAX) begin
          w_wall   = 1'b1;
          w_next.x = '0;
        end else begin
          w_next.x = r_seg[0].x + COORD_W'(1);
        end
      end
    endcase
  end

`ifdef SNAKE_WRAP_EN
  assign w_wallKill = 1'b0;
`else
  assign w_wallKill = w_wall;
`endif

  // The tail slot is safe to enter unless this step keeps it (growth).
  always_comb begin
    w_selfHit = 1'b0;
    for (int i = 1; i < MAX_LEN; i++) begin
      if ((LW'(i) < r_len) && (r_seg[i] == w_next) &&
          !((LW'(i) == r_len - LW'(1)) && !w_growing)) begin
        w_selfHit = 1'b1;
      end
    end
  end

  assign w_collide = w_wallKill || w_selfHit;

  always_comb begin
    w_query.x = COORD_W'(q_x);
    w_query.y = COORD_W'(q_y);
    w_qHit    = 1'b0;
    for (int i = 0; i < MAX_LEN; i++) begin
      if ((LW'(i) < r_len) && (r_seg[i] == w_query)) begin
        w_qHit = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_hold) begin
      r_state <= ALIVE;
    end else begin
      r_state <= w_stateNext;
    end
  end

  always_comb begin
    w_stateNext = r_state;
    if ((r_state == ALIVE) && w_step && w_collide) begin
      w_stateNext = DEAD;
    end
  end

  always_ff @(posedge clk) begin
    if (w_hold) begin
      r_dir      <= RIGHT;
      r_dirPend  <= RIGHT;
      r_len      <= LW'(INIT_LEN);
      r_growPend <= 1'b0;
      r_died     <= 1'b0;
      r_qHit     <= 1'b0;
      for (int i = 0; i < MAX_LEN; i++) begin
        r_seg[i].y <= COORD_W'(GRID_H / 2);
        r_seg[i].x <= (i < INIT_LEN) ? COORD_W'(GRID_W / 2 - i) : COORD_W'(GRID_W / 2);
      end
    end else begin
      r_died <= 1'b0;
      r_qHit <= w_qHit;
      if (grow) begin
        r_growPend <= 1'b1;
      end
      if (w_live) begin
        r_dirPend <= w_dirReq;
      end
      if (w_step) begin
        r_growPend <= 1'b0;
        if (w_collide) begin
          r_died <= 1'b1;
        end else begin
          r_dir    <= w_dirReq;
          r_seg[0] <= w_next;
          for (int i = 1; i < MAX_LEN; i++) begin
            r_seg[i] <= r_seg[i-1];
          end
          if (w_growing) begin
            r_len <= r_len + LW'(1);
          end
        end
      end
    end
  end

  assign died   = r_died;
  assign head_x = r_seg[0].x[XW-1:0];
  assign head_y = r_seg[0].y[YW-1:0];
  assign length = r_len;
  assign q_hit  = r_qHit;

endmodule

// File: tb/tb_snake_body.sv
// Scoreboard bench for snake_body with TICK_DIV=4: stimulus queues expected outputs,
// a negedge monitor pops and compares them and counts died pulses.
module tb_snake_body;
   import snake_pkg::*;

   localparam int K_HX   = 0;
   localparam int K_HY   = 1;
   localparam int K_LEN  = 2;
   localparam int K_QHIT = 3;
   localparam int K_DIED = 4;
   localparam int K_DCNT = 5;

   localparam int TIMEOUT_NS = 200000;

`ifdef SNAKE_WRAP_EN
   localparam int WALL_DIES = 0;
`else
   localparam int WALL_DIES = 1;
`endif

   typedef struct {
      string name;
      int    kind;
      int    value;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst;
   logic       init_snake;
   logic       screen_pause;
   logic [7:0] key_code;
   logic       grow;
   logic       died;
   logic [4:0] head_x;
   logic [4:0] head_y;
   logic [4:0] length;
   logic [4:0] q_x;
   logic [4:0] q_y;
   logic       q_hit;

   exp_t scoreQ[$];
   int   checks    = 0;
   int   failures  = 0;
   int   diedCount = 0;
   bit   doneFlag  = 1'b0;

   snake_body #(
      .GRID_W   (32),
      .GRID_H   (24),
      .MAX_LEN  (16),
      .INIT_LEN (4),
      .TICK_DIV (4)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .init_snake   (init_snake),
      .screen_pause (screen_pause),
      .key_code     (key_code),
      .grow         (grow),
      .died         (died),
      .head_x       (head_x),
      .head_y       (head_y),
      .length       (length),
      .q_x          (q_x),
      .q_y          (q_y),
      .q_hit        (q_hit)
   );

   always #5 clk = ~clk;

   // Monitor: count died pulses, then settle every queued expectation.
   always @(negedge clk) begin
      exp_t e;
      int   act;
      diedCount = diedCount + int'(died);
      while (scoreQ.size() > 0) begin
         e = scoreQ.pop_front();
         case (e.kind)
            K_HX:    act = int'(head_x);
            K_HY:    act = int'(head_y);
            K_LEN:   act = int'(length);
            K_QHIT:  act = int'(q_hit);
            K_DIED:  act = int'(died);
            default: act = diedCount;
         endcase
         checks = checks + 1;
         if (act != e.value) begin
            failures = failures + 1;
            $display("[TB] FAIL %s: actual=%0d expected=%0d", e.name, act, e.value);
         end
      end
   end

   // Watchdog: if the stimulus sequence never finishes, the expired wait is a failure.
   initial begin
      #(TIMEOUT_NS);
      if (!doneFlag) begin
         checks   = checks + 1;
         failures = failures + 1;
         $display("[TB] FAIL timeout: stimulus did not complete within %0d ns", TIMEOUT_NS);
         $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
         $finish;
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string name, input int kind, input int value);
      exp_t e;
      e.name  = name;
      e.kind  = kind;
      e.value = value;
      scoreQ.push_back(e);
   endtask

   task automatic applyStimulus(input logic [7:0] key, input logic g, input int cycles);
      key_code = key;
      grow     = g;
      tick(1);
      key_code = 8'h00;
      grow     = 1'b0;
      if (cycles > 1) tick(cycles - 1);
   endtask

   task automatic reinit();
      init_snake = 1'b1;
      tick(2);
      init_snake = 1'b0;
   endtask

   // Main sequence: reset, straight run, turns, wall and self collisions, growth, pause.
   initial begin
      rst          = 1'b1;
      init_snake   = 1'b0;
      screen_pause = 1'b0;
      key_code     = 8'h00;
      grow         = 1'b0;
      q_x          = 5'd13;
      q_y          = 5'd12;
      tick(3);
      checks = checks + 1;
      if ((head_x !== 5'd16) || (head_y !== 5'd12) || (length !== 5'd4) ||
          (died !== 1'b0) || (q_hit !== 1'b0)) begin
         failures = failures + 1;
         $display("[TB] FAIL reset_state: hx=%0d hy=%0d len=%0d died=%0b qhit=%0b",
                  head_x, head_y, length, died, q_hit);
      end
      checkOutput("rst_hx", K_HX, 16);
      checkOutput("rst_hy", K_HY, 12);
      checkOutput("rst_len", K_LEN, 4);
      checkOutput("rst_died", K_DIED, 0);
      checkOutput("rst_qhit", K_QHIT, 0);
      rst = 1'b0;

      tick(1);
      checkOutput("q_init_tail", K_QHIT, 1);
      tick(3);
      checkOutput("step1_hx", K_HX, 17);
      tick(1);
      checkOutput("q_tail_vacated", K_QHIT, 0);
      q_x = 5'd14;
      tick(1);
      checkOutput("q_new_tail", K_QHIT, 1);
      tick(2);
      checkOutput("step2_hx", K_HX, 18);
      for (int i = 0; i < 2; i++) applyStimulus(8'h00, 1'b0, 4);
      checkOutput("run4_hx", K_HX, 20);
      checkOutput("run4_hy", K_HY, 12);
      checkOutput("run4_len", K_LEN, 4);
      checkOutput("run4_dcnt", K_DCNT, 0);

      applyStimulus(KEY_LEFT, 1'b0, 4);
      checkOutput("reverse_ignored_hx", K_HX, 21);
      checkOutput("reverse_ignored_hy", K_HY, 12);
      applyStimulus(KEY_UP, 1'b0, 4);
      checkOutput("turn_up_hx", K_HX, 21);
      checkOutput("turn_up_hy", K_HY, 11);

      applyStimulus(KEY_RIGHT, 1'b0, 4);
      for (int i = 0; i < 9; i++) applyStimulus(8'h00, 1'b0, 4);
      checkOutput("at_wall_hx", K_HX, 31);
      checkOutput("at_wall_dcnt", K_DCNT, 0);
      applyStimulus(8'h00, 1'b0, 4);
      checkOutput("wall_died_level", K_DIED, WALL_DIES);
      checkOutput("wall_hx", K_HX, WALL_DIES ? 31 : 0);
      tick(1);
      checkOutput("wall_died_drop", K_DIED, 0);
      checkOutput("wall_dcnt", K_DCNT, WALL_DIES);
      tick(20);
      checkOutput("dead_frozen_hx", K_HX, WALL_DIES ? 31 : 5);
      checkOutput("dead_frozen_hy", K_HY, 11);
      checkOutput("dead_dcnt", K_DCNT, WALL_DIES);

      reinit();
      checkOutput("init_hx", K_HX, 16);
      checkOutput("init_hy", K_HY, 12);
      checkOutput("init_len", K_LEN, 4);
      checkOutput("init_died", K_DIED, 0);

      applyStimulus(8'h00, 1'b1, 4);
      checkOutput("grow1_len", K_LEN, 5);
      checkOutput("grow1_hx", K_HX, 17);
      q_x = 5'd13;
      q_y = 5'd12;
      tick(1);
      checkOutput("q_old_tail_kept", K_QHIT, 1);
      applyStimulus(KEY_UP, 1'b0, 3);
      checkOutput("self_up_hy", K_HY, 11);
      applyStimulus(KEY_LEFT, 1'b0, 4);
      checkOutput("self_left_hx", K_HX, 16);
      applyStimulus(KEY_DOWN, 1'b0, 4);
      checkOutput("self_died_level", K_DIED, 1);
      checkOutput("self_hx", K_HX, 16);
      checkOutput("self_hy", K_HY, 11);
      tick(1);
      checkOutput("self_dcnt", K_DCNT, WALL_DIES + 1);

      reinit();
      applyStimulus(KEY_UP, 1'b0, 4);
      applyStimulus(KEY_LEFT, 1'b0, 4);
      applyStimulus(KEY_DOWN, 1'b0, 4);
      checkOutput("chase_died", K_DIED, 0);
      checkOutput("chase_hx", K_HX, 15);
      checkOutput("chase_hy", K_HY, 12);
      tick(1);
      checkOutput("chase_dcnt", K_DCNT, WALL_DIES + 1);

      reinit();
      for (int i = 0; i < 13; i++) applyStimulus(8'h00, 1'b1, 4);
      checkOutput("sat_len", K_LEN, 16);
      checkOutput("sat_hx", K_HX, 29);
      checkOutput("sat_hy", K_HY, 12);
      q_x = 5'd14;
      tick(1);
      checkOutput("sat_q_last", K_QHIT, 1);
      q_x = 5'd13;
      tick(1);
      checkOutput("sat_q_beyond", K_QHIT, 0);

      reinit();
      applyStimulus(8'h00, 1'b0, 4);
      checkOutput("pause_pre_hx", K_HX, 17);
      tick(2);
      screen_pause = 1'b1;
      key_code     = KEY_UP;
      tick(20);
      checkOutput("pause_hx", K_HX, 17);
      checkOutput("pause_hy", K_HY, 12);
      key_code     = 8'h00;
      screen_pause = 1'b0;
      tick(1);
      checkOutput("unpause_cnt_hold_hx", K_HX, 17);
      tick(1);
      checkOutput("unpause_step_hx", K_HX, 18);
      checkOutput("unpause_key_ignored_hy", K_HY, 12);
      checkOutput("final_len", K_LEN, 4);
      checkOutput("final_dcnt", K_DCNT, WALL_DIES + 1);

      tick(2);
      doneFlag = 1'b1;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
